// File: rtl/bird_ctrl_param_if.sv
// Bird controller bus: player/collision inputs, draw-engine handshake and
// status outputs, grouped so the controller and its environment share one
// connection.
//
// Draw handshake: the controller raises draw_req (with draw_erase selecting
// the paint colour) and holds both steady until the draw engine returns a
// one-cycle draw_done. A transfer completes on the rising clk edge where
// draw_req=1 and draw_done=1. draw_done arriving while draw_req=0 has no
// effect.
//
// Signals:
//   press_key  flap button, level (rising edge = flap)
//   touched    collision flag from pipe logic, level
//   draw_done  one-cycle completion pulse from the draw engine
//   draw_req   draw request, held until draw_done
//   draw_erase 1 = background colour, 0 = bird colour
//   bird_y     current bird row
//   state_out  controller FSM state code
//   game_over  high while the game is stopped
// Modports: master = controller, slave = environment (buttons, pipes, draw engine).
interface bird_ctrl_param_if #(
    parameter int Y_W = 7
);
    logic           press_key;
    logic           touched;
    logic           draw_done;
    logic           draw_req;
    logic           draw_erase;
    logic [Y_W-1:0] bird_y;
    logic [2:0]     state_out;
    logic           game_over;

    modport master (
        input  press_key, touched, draw_done,
        output draw_req, draw_erase, bird_y, state_out, game_over
    );

    modport slave (
        output press_key, touched, draw_done,
        input  draw_req, draw_erase, bird_y, state_out, game_over
    );
endinterface

// File: rtl/bird_ctrl_param.sv
// Flappy-bird style bird controller. Once per frame it erases the bird,
// moves it (rise after a flap, then fall), redraws it, and stops the game on
// a collision or when the bird reaches the floor. A flap while stopped
// restarts the game from the spawn row.
//
// Ports:
//   clk      system clock, all state on the rising edge
//   resetn   asynchronous reset, active high
//   io_bird  controller side of bird_ctrl_param_if (master modport)
module bird_ctrl_param #(
    parameter int Y_W         = 7,
    parameter int Y_START     = 60,
    parameter int Y_CEIL      = 0,
    parameter int Y_FLOOR     = 112,
    parameter int RISE_STEP   = 2,
    parameter int FALL_STEP   = 1,
    parameter int RISE_FRAMES = 8,
    parameter int FRAME_TICKS = 833333
) (
    input  logic clk,
    input  logic resetn,
    bird_ctrl_param_if.master io_bird
);
    localparam int FC_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int RC_W = $clog2(RISE_FRAMES) + 1;
    localparam int YX_W = Y_W + 1;

    localparam logic [FC_W-1:0] C_FT_LAST   = FC_W'(FRAME_TICKS - 1);
    localparam logic [RC_W-1:0] C_RISE_LAST = RC_W'(RISE_FRAMES - 1);
    localparam logic [Y_W-1:0]  C_START     = Y_W'(Y_START);
    localparam logic [Y_W-1:0]  C_CEIL      = Y_W'(Y_CEIL);
    localparam logic [Y_W-1:0]  C_FLOOR     = Y_W'(Y_FLOOR);
    localparam logic [YX_W-1:0] C_RISE_X    = YX_W'(RISE_STEP);
    localparam logic [YX_W-1:0] C_FALL_X    = YX_W'(FALL_STEP);
    localparam logic [YX_W-1:0] C_FLOOR_X   = YX_W'(Y_FLOOR);

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_ERASE  = 3'd1,
        S_UPDATE = 3'd2,
        S_DRAW   = 3'd3,
        S_WAIT   = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        M_IDLE    = 2'd0,
        M_RISING  = 2'd1,
        M_FALLING = 2'd2
    } mode_t;

    state_t          r_state;
    state_t          w_state_nxt;
    mode_t           r_mode;
    logic [Y_W-1:0]  r_bird_y;
    logic [FC_W-1:0] r_frame_cnt;
    logic [RC_W-1:0] r_rise_cnt;
    logic            r_key_prev;
    logic            r_flap_pending;
    logic            r_hit;
    logic            r_restart;

    logic            w_frame_tick;
    logic            w_flap_edge;
    logic            w_draw_req;
    logic            w_draw_erase;
    logic            w_game_over;
    logic [RC_W-1:0] w_rise_cnt_base;
    logic [YX_W-1:0] w_y_ext;
    logic [YX_W-1:0] w_rise_sub;
    logic [YX_W-1:0] w_fall_sum;
    logic            w_rise_clamp;
    logic [Y_W-1:0]  w_rise_y;
    logic [Y_W-1:0]  w_fall_y;
    logic            w_rise_done;

    assign w_frame_tick = (r_frame_cnt == C_FT_LAST);
    assign w_flap_edge  = io_bird.press_key & ~r_key_prev;

    // A fresh flap restarts the rise sequence from count 0 in the same update.
    assign w_rise_cnt_base = r_flap_pending ? '0 : r_rise_cnt;

    // Motion arithmetic is one bit wider than bird_y: the extra MSB of the
    // subtraction is the borrow, so a step past row 0 clamps instead of wrapping.
    assign w_y_ext      = {1'b0, r_bird_y};
    assign w_rise_sub   = w_y_ext - C_RISE_X;
    assign w_rise_clamp = w_rise_sub[Y_W] || (w_rise_sub[Y_W-1:0] < C_CEIL);
    assign w_rise_y     = w_rise_clamp ? C_CEIL : w_rise_sub[Y_W-1:0];
    assign w_rise_done  = (w_rise_cnt_base == C_RISE_LAST) || (w_rise_y == C_CEIL);
    assign w_fall_sum   = w_y_ext + C_FALL_X;
    assign w_fall_y     = (w_fall_sum >= C_FLOOR_X) ? C_FLOOR : w_fall_sum[Y_W-1:0];

    // State register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state <= S_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt  = S_START;
        w_draw_req   = 1'b0;
        w_draw_erase = 1'b0;
        w_game_over  = 1'b0;
        case (r_state)
            S_START: begin
                w_state_nxt = S_DRAW;
            end
            S_DRAW: begin
                w_draw_req  = 1'b1;
                w_state_nxt = S_DRAW;
                if (io_bird.draw_done) begin
                    w_state_nxt = r_hit ? S_STOP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_state_nxt = S_WAIT;
                if (w_frame_tick && ((r_mode != M_IDLE) || r_flap_pending)) begin
                    w_state_nxt = S_ERASE;
                end
            end
            S_ERASE: begin
                w_draw_req   = 1'b1;
                w_draw_erase = 1'b1;
                w_state_nxt  = io_bird.draw_done ? S_UPDATE : S_ERASE;
            end
            S_UPDATE: begin
                w_state_nxt = S_DRAW;
            end
            S_STOP: begin
                w_game_over = 1'b1;
                w_state_nxt = w_flap_edge ? S_ERASE : S_STOP;
            end
            default: begin
                w_state_nxt = S_START;
            end
        endcase
    end

    // Frame timing, input flags and bird motion
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_frame_cnt    <= '0;
            r_key_prev     <= 1'b0;
            r_flap_pending <= 1'b0;
            r_hit          <= 1'b0;
            r_restart      <= 1'b0;
            r_rise_cnt     <= '0;
            r_mode         <= M_IDLE;
            r_bird_y       <= C_START;
        end else begin
            r_frame_cnt <= w_frame_tick ? '0 : r_frame_cnt + FC_W'(1);
            r_key_prev  <= io_bird.press_key;

            // A flap arriving in the update cycle itself is kept for the next frame.
            if (w_flap_edge) begin
                r_flap_pending <= 1'b1;
            end else if (r_state == S_UPDATE) begin
                r_flap_pending <= 1'b0;
            end

            if (io_bird.touched && (r_state != S_STOP)) begin
                r_hit <= 1'b1;
            end

            if ((r_state == S_STOP) && w_flap_edge) begin
                r_restart <= 1'b1;
            end

            if (r_state == S_UPDATE) begin
                r_restart <= 1'b0;
                if (r_restart) begin
                    r_bird_y       <= C_START;
                    r_mode         <= M_IDLE;
                    r_rise_cnt     <= '0;
                    r_hit          <= 1'b0;
                    r_flap_pending <= 1'b0;
                end else if (r_hit) begin
                    // Frozen in place until the stop screen is reached.
                end else if (r_flap_pending || (r_mode == M_RISING)) begin
                    r_bird_y   <= w_rise_y;
                    r_rise_cnt <= w_rise_cnt_base + RC_W'(1);
                    r_mode     <= w_rise_done ? M_FALLING : M_RISING;
                end else if (r_mode == M_FALLING) begin
                    r_bird_y <= w_fall_y;
                    if (w_fall_y == C_FLOOR) begin
                        r_hit <= 1'b1;
                    end
                end
            end
        end
    end

    assign io_bird.draw_req   = w_draw_req;
    assign io_bird.draw_erase = w_draw_erase;
    assign io_bird.game_over  = w_game_over;
    assign io_bird.bird_y     = r_bird_y;
    assign io_bird.state_out  = r_state;
endmodule
